// File: rtl/window_5x5_gen_if.sv
// Pixel-in / window-out stream bundle for window_5x5_gen.
// The slave modport is the window generator; master is the upstream/downstream side.
interface window_5x5_gen_if;
   logic [7:0]   in_pixel;
   logic         in_valid;
   logic         in_sof;
   logic         in_ready;
   logic [199:0] out_window;
   logic         out_valid;
   logic         out_ready;
   logic         frame_done;

   modport master (
      output in_pixel, in_valid, in_sof, out_ready,
      input  in_ready, out_window, out_valid, frame_done
   );

   modport slave (
      input  in_pixel, in_valid, in_sof, out_ready,
      output in_ready, out_window, out_valid, frame_done
   );
endinterface

// File: rtl/window_5x5_gen.sv
// 4-line buffer plus 5x5 shift window feeding the Sobel filters; emits only fully interior windows.
// Optional macro WIN_COORD_EN adds out_x/out_y window-centre coordinate ports.
module window_5x5_gen #(
   parameter int unsigned IMG_WIDTH  = 64,
   parameter int unsigned IMG_HEIGHT = 64
) (
   input  logic               clk,
   input  logic               rst,
   window_5x5_gen_if.slave    bus
`ifdef WIN_COORD_EN
   ,
   output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
   output logic [$clog2(IMG_HEIGHT)-1:0] out_y
`endif
);

   localparam int unsigned CW  = $clog2(IMG_WIDTH);
   localparam int unsigned RW  = $clog2(IMG_HEIGHT);
   localparam int unsigned PW  = 8;
   localparam int unsigned K   = 5;
   localparam int unsigned NLB = K - 1;
   localparam int unsigned WW  = K * K * PW;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [CW-1:0] cur_col;
   logic [RW-1:0] cur_row;
   logic          in_ready_c;
   logic          accept;
   logic          line_end;
   logic          frame_end;
   logic          win_done;

   logic [PW-1:0] lb [NLB][IMG_WIDTH];
   logic [PW-1:0] new_col [K];
   logic [WW-1:0] win_q;
   logic [WW-1:0] win_d;
   logic          out_valid_q;
   logic          frame_done_q;

   assign in_ready_c = !out_valid_q || bus.out_ready;
   assign accept     = bus.in_valid && in_ready_c;

   // An accepted start-of-frame pixel overrides whatever the counters hold.
   always_comb begin
      cur_col   = bus.in_sof ? '0 : col;
      cur_row   = bus.in_sof ? '0 : row;
      line_end  = (cur_col == CW'(IMG_WIDTH - 1));
      frame_end = line_end && (cur_row == RW'(IMG_HEIGHT - 1));
      win_done  = (cur_row >= RW'(NLB)) && (cur_col >= CW'(NLB));
   end

   // Incoming column: oldest line at the top, live pixel at the bottom.
   always_comb begin
      for (int r = 0; r < int'(NLB); r++) begin
         new_col[r] = lb[NLB-1-r][cur_col];
      end
      new_col[K-1] = bus.in_pixel;
   end

   always_comb begin
      win_d = win_q;
      for (int r = 0; r < int'(K); r++) begin
         for (int c = 0; c < int'(K) - 1; c++) begin
            win_d[(r*K + c)*PW +: PW] = win_q[(r*K + c + 1)*PW +: PW];
         end
         win_d[(r*K + K - 1)*PW +: PW] = new_col[r];
      end
   end

   // Line storage is intentionally unreset; output gating makes stale data invisible.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = int'(NLB) - 1; i > 0; i--) begin
            lb[i][cur_col] <= lb[i-1][cur_col];
         end
         lb[0][cur_col] <= bus.in_pixel;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col          <= '0;
         row          <= '0;
         win_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= accept && frame_end;
         if (accept) begin
            win_q       <= win_d;
            out_valid_q <= win_done;
            if (line_end) begin
               col <= '0;
               row <= frame_end ? '0 : cur_row + RW'(1);
            end else begin
               col <= cur_col + CW'(1);
               row <= cur_row;
            end
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef WIN_COORD_EN
   // Centre of the window completed by this pixel; held with the window under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_x <= '0;
         out_y <= '0;
      end else if (accept && win_done) begin
         out_x <= cur_col - CW'(2);
         out_y <= cur_row - RW'(2);
      end
   end
`endif

   assign bus.in_ready   = in_ready_c;
   assign bus.out_window = win_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// Directed scoreboard bench for window_5x5_gen on an 8x8 frame (define WIN_COORD_EN to check out_x/out_y).
module tb_window_5x5_gen;
   localparam int W = 8;
   localparam int H = 8;
   localparam int NWIN = (W - 4) * (H - 4);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   window_5x5_gen_if bus ();
`ifdef WIN_COORD_EN
   logic [$clog2(W)-1:0] out_x;
   logic [$clog2(H)-1:0] out_y;
`endif

   window_5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef WIN_COORD_EN
      ,
      .out_x (out_x),
      .out_y (out_y)
`endif
   );

   typedef struct {
      logic [199:0] w;
      int           x;
      int           y;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  img [H][W];
   int          mr, mc, n_frame;
   bit          first_seen;
   int          errors, checks;
   int          pop_cnt;
   int          cyc;

   task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      mr = 0; mc = 0; n_frame = 0; first_seen = 1'b0;
      q.delete();
   endtask

   // Reference model: frame image plus coordinate tracking; pushes expected windows.
   task automatic model_accept(input bit sof, input logic [7:0] pix, output bit last);
      exp_t e;
      if (sof) begin
         mr = 0; mc = 0; n_frame = 0;
      end
      if (n_frame == 0) first_seen = 1'b0;
      n_frame++;
      img[mr][mc] = pix;
      if (mr >= 4 && mc >= 4) begin
         e.w = '0;
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               e.w[(r*5 + c)*8 +: 8] = img[mr-4+r][mc-4+c];
         e.x = mc - 2;
         e.y = mr - 2;
         q.push_back(e);
      end
      last = (mr == H - 1) && (mc == W - 1);
      if (mc == W - 1) begin
         mc = 0;
         mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
         mc++;
      end
      if (last) n_frame = 0;
   endtask

   task automatic step(input bit v, input bit sof, input logic [7:0] pix, input bit ordy, output bit acc);
      bit last;
      logic [199:0] w;
      last = 1'b0;
      @(negedge clk);
      bus.in_valid = v; bus.in_sof = sof; bus.in_pixel = pix; bus.out_ready = ordy;
      #1;
      chk("in_ready", 200'(bus.in_ready), 200'(!bus.out_valid || ordy));
      acc = v && bus.in_ready;
      if (acc) model_accept(sof, pix, last);
      @(posedge clk);
      #1;
      cyc++;
      chk("frame_done", 200'(bus.frame_done), 200'(last));
      if (!first_seen && bus.out_valid) begin
         first_seen = 1'b1;
         w = bus.out_window;
         chk("first_latency", 200'(n_frame), 200'(37));
         chk("first_w0", 200'(w[7:0]), 200'(0));
         chk("first_w4", 200'(w[39:32]), 200'(4));
         chk("first_w24", 200'(w[199:192]), 200'(36));
         chk("first_centre", 200'(w[103:96]), 200'(18));
`ifdef WIN_COORD_EN
         chk("first_x", 200'(out_x), 200'(2));
         chk("first_y", 200'(out_y), 200'(2));
`endif
      end
      if (cyc > 20000) begin
         $display("FAIL timeout: cycles=%0d exceeded budget", cyc);
         $fatal(1, "cycle budget exhausted");
      end
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1, acc);
   endtask

   // Feed n accepted pixels; optional random gaps and one 3-cycle backpressure stall.
   task automatic run_pixels(input int n, input bit ramp, input bit gaps, input bit sof_first, input bit do_bp);
      int   sent;
      int   stall_left;
      bit   bp_done, acc, v, sof, ordy;
      int   pr, pc;
      logic [7:0]   pix;
      logic [199:0] held;
      sent = 0; stall_left = 0; bp_done = 1'b0; held = '0;
      while (sent < n) begin
         if (do_bp && !bp_done && stall_left == 0 && pop_cnt >= 2 && bus.out_valid) begin
            stall_left = 3;
            bp_done    = 1'b1;
            held       = bus.out_window;
         end
         sof  = sof_first && (sent == 0);
         pr   = sof ? 0 : mr;
         pc   = sof ? 0 : mc;
         pix  = ramp ? 8'(pr*8 + pc) : 8'(200 + sent);
         v    = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         ordy = (stall_left == 0);
         step(v, sof && v, pix, ordy, acc);
         if (stall_left > 0) begin
            chk("stall_no_accept", 200'(acc), 200'(0));
            chk("stall_hold_window", bus.out_window, held);
            chk("stall_hold_valid", 200'(bus.out_valid), 200'(1));
            stall_left--;
         end
         if (acc) sent++;
      end
   endtask

   task automatic end_frame(input string tag);
      idle(3);
      chk({tag, "_win_count"}, 200'(pop_cnt), 200'(NWIN));
      chk({tag, "_queue_empty"}, 200'(q.size()), 200'(0));
      pop_cnt = 0;
   endtask

   // Consumer side: a transfer happens on the next edge when valid && ready.
   always @(negedge clk) begin
      exp_t e;
      #2;
      if (!rst && bus.out_valid && bus.out_ready) begin
         chk("pop_expected", 200'(q.size() > 0), 200'(1));
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("window", bus.out_window, e.w);
`ifdef WIN_COORD_EN
            chk("out_x", 200'(out_x), 200'(e.x));
            chk("out_y", 200'(out_y), 200'(e.y));
`endif
            pop_cnt++;
         end
      end
   end

   initial begin
      errors = 0; checks = 0; pop_cnt = 0; cyc = 0;
      model_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_pixel = '0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 200'(bus.out_valid), 200'(0));
      chk("rst_out_window", bus.out_window, 200'(0));
      chk("rst_frame_done", 200'(bus.frame_done), 200'(0));
      @(negedge clk);
      rst = 1'b0;

      // Plain ramp frame.
      run_pixels(W*H, 1'b1, 1'b0, 1'b0, 1'b0);
      end_frame("ramp");

      // Ramp frame with a stall on the output.
      run_pixels(W*H, 1'b1, 1'b0, 1'b0, 1'b1);
      end_frame("backpressure");

      // Ramp frame with random input gaps.
      run_pixels(W*H, 1'b1, 1'b1, 1'b0, 1'b0);
      end_frame("gaps");

      // Reset in the middle of a frame, then a fresh frame.
      run_pixels(20, 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1; bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 200'(bus.out_valid), 200'(0));
      chk("midrst_out_window", bus.out_window, 200'(0));
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      pop_cnt = 0;
      run_pixels(W*H, 1'b1, 1'b0, 1'b0, 1'b0);
      end_frame("after_rst");

      // Partial frame of junk, then a start-of-frame resync.
      run_pixels(10, 1'b0, 1'b0, 1'b0, 1'b0);
      run_pixels(W*H, 1'b1, 1'b0, 1'b1, 1'b0);
      end_frame("sof_resync");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
